// File: rtl/vic_pkg.sv
// Shared types and helpers for the nested vectored interrupt controller.
package vic_pkg;

  typedef enum logic {
    RUN,
    WAIT
  } vic_state_e;

  // Context entry at the default widths (ADDR_W=32, CC_W=4, N_IRQ=8); the
  // controller re-declares it at its own parameter widths for the stack.
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cc;
    logic [3:0]  level;
  } ctx_t;

  // "No ISR active" level: one past the lowest-priority source index.
  function automatic int unsigned idle_level(input int unsigned n_irq);
    return n_irq;
  endfunction

  // Computed at 64 bits; the caller truncates to its address width.
  function automatic logic [63:0] vec_addr(input logic [63:0] base,
                                           input int unsigned idx,
                                           input int unsigned shift);
    return base + (64'(idx) << shift);
  endfunction

endpackage

// File: rtl/vic_ctx_stack.sv
// LIFO of interrupt contexts; the parent never pushes when full or pops when empty.
module vic_ctx_stack
  import vic_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = ctx_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] ptr_q;
  entry_t           mem [DEPTH];

  assign full  = (ptr_q == PTR_W'(DEPTH));
  assign empty = (ptr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (push && !full) begin
      ptr_q <= ptr_q + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && !full && ptr_q == PTR_W'(i)) begin
        mem[i] <= wdata;
      end
    end
  end

  // Top of stack is the entry just below the pointer.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ptr_q == PTR_W'(i + 1)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/vic_nested_ctrl.sv
// Fixed-priority nested interrupt controller: arbitrates sources, stacks context, redirects fetch.
module vic_nested_ctrl
  import vic_pkg::*;
#(
  parameter int unsigned N_IRQ     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CC_W      = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE = '0,
  parameter int unsigned VEC_SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IRQ-1:0]           i_irq,
  input  logic [N_IRQ-1:0]           i_irq_en,
  input  logic [ADDR_W-1:0]          i_PC,
  input  logic [CC_W-1:0]            i_CCodes,
  input  logic                       i_NOT_FLUSH,
  input  logic                       i_reti,
  output logic                       o_IRQ_PC,
  output logic [ADDR_W-1:0]          o_VIC_iaddr,
  output logic [CC_W-1:0]            o_VIC_CCodes,
  output logic                       o_VIC_CCodes_ctrl,
  output logic                       o_IRQ_VIC,
  output logic [N_IRQ-1:0]           o_irq_ack,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_err
);

  localparam int unsigned LVL_W = $clog2(N_IRQ + 1);
  localparam int unsigned D_W   = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] IDLE = LVL_W'(idle_level(N_IRQ));

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [CC_W-1:0]   cc;
    logic [LVL_W-1:0]  level;
  } entry_t;

  vic_state_e        state_q, state_d;
  logic [LVL_W-1:0]  act_q, act_d;
  logic [D_W-1:0]    depth_q, depth_d;
  logic              err_q, err_d;
  logic              irq_pc_d, cc_ctrl_d;
  logic [ADDR_W-1:0] iaddr_d;
  logic [CC_W-1:0]   cc_d;
  logic [N_IRQ-1:0]  ack_d;

  logic [N_IRQ-1:0]  elig;
  logic              win_valid;
  logic [LVL_W-1:0]  win_idx;
  logic              preempt;
  logic              push, pop, full, empty;
  entry_t            push_entry, top_entry;

  assign elig = i_irq & i_irq_en;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = IDLE;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (elig[i] && !win_valid) begin
        win_valid = 1'b1;
        win_idx   = LVL_W'(i);
      end
    end
  end

  // act is IDLE at depth 0, so the comparison alone covers the idle case.
  assign preempt    = win_valid && (empty || win_idx < act_q);
  assign push_entry = '{pc: i_PC, cc: i_CCodes, level: act_q};

  vic_ctx_stack #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (top_entry),
    .full  (full),
    .empty (empty)
  );

  // RUN and WAIT share arbitration; WAIT only records that a take is stalled on flush.
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    depth_d   = depth_q;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    irq_pc_d  = 1'b0;
    cc_ctrl_d = 1'b0;
    ack_d     = '0;
    iaddr_d   = o_VIC_iaddr;
    cc_d      = o_VIC_CCodes;
    if (i_reti && !empty) begin
      pop       = 1'b1;
      act_d     = top_entry.level;
      depth_d   = depth_q - D_W'(1);
      iaddr_d   = top_entry.pc;
      cc_d      = top_entry.cc;
      irq_pc_d  = 1'b1;
      cc_ctrl_d = 1'b1;
      state_d   = RUN;
    end else if (i_reti) begin
      err_d = 1'b1;
    end else if (preempt && !full) begin
      if (i_NOT_FLUSH) begin
        push     = 1'b1;
        act_d    = win_idx;
        depth_d  = depth_q + D_W'(1);
        iaddr_d  = ADDR_W'(vec_addr(64'(VEC_BASE), 32'(win_idx), VEC_SHIFT));
        irq_pc_d = 1'b1;
        ack_d    = N_IRQ'(1) << win_idx;
        state_d  = RUN;
      end else begin
        state_d = WAIT;
      end
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= RUN;
      act_q             <= IDLE;
      depth_q           <= '0;
      err_q             <= 1'b0;
      o_IRQ_PC          <= 1'b0;
      o_VIC_iaddr       <= '0;
      o_VIC_CCodes      <= '0;
      o_VIC_CCodes_ctrl <= 1'b0;
      o_IRQ_VIC         <= 1'b0;
      o_irq_ack         <= '0;
    end else begin
      state_q           <= state_d;
      act_q             <= act_d;
      depth_q           <= depth_d;
      err_q             <= err_d;
      o_IRQ_PC          <= irq_pc_d;
      o_VIC_iaddr       <= iaddr_d;
      o_VIC_CCodes      <= cc_d;
      o_VIC_CCodes_ctrl <= cc_ctrl_d;
      o_IRQ_VIC         <= (depth_d != '0);
      o_irq_ack         <= ack_d;
    end
  end

  assign o_depth = depth_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_vic_nested_ctrl.sv
// Directed bench for vic_nested_ctrl built with a two-entry context stack.
module tb_vic_nested_ctrl;
  import vic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq, irq_en;
  logic [31:0] pc;
  logic [3:0]  ccodes;
  logic        not_flush, reti;
  logic        irq_pc, cc_ctrl, irq_vic, err;
  logic [31:0] iaddr;
  logic [3:0]  cc_out;
  logic [7:0]  ack;
  logic [1:0]  depth;

  int checks   = 0;
  int failures = 0;

  vic_nested_ctrl #(
    .N_IRQ     (8),
    .DEPTH     (2),
    .ADDR_W    (32),
    .CC_W      (4),
    .VEC_BASE  (32'h0),
    .VEC_SHIFT (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_irq             (irq),
    .i_irq_en          (irq_en),
    .i_PC              (pc),
    .i_CCodes          (ccodes),
    .i_NOT_FLUSH       (not_flush),
    .i_reti            (reti),
    .o_IRQ_PC          (irq_pc),
    .o_VIC_iaddr       (iaddr),
    .o_VIC_CCodes      (cc_out),
    .o_VIC_CCodes_ctrl (cc_ctrl),
    .o_IRQ_VIC         (irq_vic),
    .o_irq_ack         (ack),
    .o_depth           (depth),
    .o_err             (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_irq_pc"}, 64'(irq_pc), 64'h0);
    chk({tag, "_iaddr"}, 64'(iaddr), 64'h0);
    chk({tag, "_cc"}, 64'(cc_out), 64'h0);
    chk({tag, "_cc_ctrl"}, 64'(cc_ctrl), 64'h0);
    chk({tag, "_irq_vic"}, 64'(irq_vic), 64'h0);
    chk({tag, "_ack"}, 64'(ack), 64'h0);
    chk({tag, "_depth"}, 64'(depth), 64'h0);
    chk({tag, "_err"}, 64'(err), 64'h0);
  endtask

  initial begin
    rst = 1'b1; irq = '0; irq_en = 8'hFF; pc = '0; ccodes = '0;
    not_flush = 1'b1; reti = 1'b0;
    step(); step();
    chk_idle_outputs("reset");

    // Masked source is not taken.
    rst = 1'b0; irq = 8'h08; irq_en = 8'hF7;
    step();
    chk("mask_no_take", 64'(irq_pc), 64'h0);
    irq = '0; irq_en = 8'hFF;
    step();

    // Single IRQ3 entry and return.
    irq = 8'h08; pc = 32'h100; ccodes = 4'hA;
    step();
    chk("single_irq_pc", 64'(irq_pc), 64'h1);
    chk("single_iaddr", 64'(iaddr), 64'h30);
    chk("single_ack", 64'(ack), 64'h08);
    chk("single_depth", 64'(depth), 64'h1);
    chk("single_irq_vic", 64'(irq_vic), 64'h1);
    irq = '0; pc = 32'h999; ccodes = 4'h0;
    step();
    chk("single_pulse_end", 64'(irq_pc), 64'h0);
    chk("single_ack_end", 64'(ack), 64'h0);
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("ret_irq_pc", 64'(irq_pc), 64'h1);
    chk("ret_iaddr", 64'(iaddr), 64'h100);
    chk("ret_cc", 64'(cc_out), 64'hA);
    chk("ret_cc_ctrl", 64'(cc_ctrl), 64'h1);
    chk("ret_depth", 64'(depth), 64'h0);
    chk("ret_irq_vic", 64'(irq_vic), 64'h0);
    step();
    chk("ret_cc_ctrl_end", 64'(cc_ctrl), 64'h0);

    // Flush stall on IRQ0.
    not_flush = 1'b0; irq = 8'h01; pc = 32'h200; ccodes = 4'h3;
    step(); step(); step();
    chk("stall_no_redirect", 64'(irq_pc), 64'h0);
    chk("stall_depth", 64'(depth), 64'h0);
    not_flush = 1'b1;
    step();
    chk("stall_release_pc", 64'(irq_pc), 64'h1);
    chk("stall_release_iaddr", 64'(iaddr), 64'h0);
    chk("stall_release_ack", 64'(ack), 64'h01);
    irq = '0;
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("stall_ret_iaddr", 64'(iaddr), 64'h200);
    chk("stall_ret_cc", 64'(cc_out), 64'h3);
    step();

    // Nesting: IRQ3 active, IRQ5 blocked, IRQ1 nests.
    irq = 8'h08; pc = 32'h300; ccodes = 4'h1;
    step();
    chk("nest_l1_iaddr", 64'(iaddr), 64'h30);
    irq = '0;
    step();
    irq = 8'h20;
    step(); step();
    chk("nest_low_blocked", 64'(irq_pc), 64'h0);
    chk("nest_low_depth", 64'(depth), 64'h1);
    irq = 8'h22; pc = 32'h340; ccodes = 4'h2;
    step();
    chk("nest_l2_pc", 64'(irq_pc), 64'h1);
    chk("nest_l2_iaddr", 64'(iaddr), 64'h10);
    chk("nest_l2_ack", 64'(ack), 64'h02);
    chk("nest_l2_depth", 64'(depth), 64'h2);
    irq = '0;
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("nest_ret1_iaddr", 64'(iaddr), 64'h340);
    chk("nest_ret1_cc", 64'(cc_out), 64'h2);
    chk("nest_ret1_depth", 64'(depth), 64'h1);
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("nest_ret2_iaddr", 64'(iaddr), 64'h300);
    chk("nest_ret2_cc", 64'(cc_out), 64'h1);
    chk("nest_ret2_depth", 64'(depth), 64'h0);
    step();

    // Full stack: IRQ2, IRQ1 taken; IRQ0 held until a return.
    irq = 8'h04; pc = 32'h400; ccodes = 4'h4;
    step();
    chk("full_l1_iaddr", 64'(iaddr), 64'h20);
    irq = '0;
    step();
    irq = 8'h02; pc = 32'h410; ccodes = 4'h5;
    step();
    chk("full_l2_iaddr", 64'(iaddr), 64'h10);
    chk("full_l2_depth", 64'(depth), 64'h2);
    irq = '0;
    step();
    irq = 8'h01;
    step(); step();
    chk("full_held_pc", 64'(irq_pc), 64'h0);
    chk("full_held_ack", 64'(ack), 64'h0);
    chk("full_held_depth", 64'(depth), 64'h2);
    reti = 1'b1; pc = 32'h420; ccodes = 4'h6;
    step();
    reti = 1'b0;
    chk("full_ret_pc", 64'(irq_pc), 64'h1);
    chk("full_ret_iaddr", 64'(iaddr), 64'h410);
    chk("full_ret_ack", 64'(ack), 64'h0);
    chk("full_ret_depth", 64'(depth), 64'h1);
    step();
    chk("full_tail_pc", 64'(irq_pc), 64'h1);
    chk("full_tail_iaddr", 64'(iaddr), 64'h0);
    chk("full_tail_ack", 64'(ack), 64'h01);
    chk("full_tail_depth", 64'(depth), 64'h2);
    irq = '0;
    step();
    reti = 1'b1;
    step();
    chk("full_pop1_iaddr", 64'(iaddr), 64'h420);
    step();
    reti = 1'b0;
    chk("full_pop2_iaddr", 64'(iaddr), 64'h400);
    chk("full_pop2_cc", 64'(cc_out), 64'h4);
    chk("full_pop2_depth", 64'(depth), 64'h0);
    step();

    // Simultaneous reti and IRQ0 at depth 1 with IRQ4 active.
    irq = 8'h10; pc = 32'h500; ccodes = 4'h7;
    step();
    chk("sim_entry_iaddr", 64'(iaddr), 64'h40);
    irq = '0;
    step();
    irq = 8'h01; reti = 1'b1; pc = 32'h600;
    step();
    reti = 1'b0;
    chk("sim_ret_iaddr", 64'(iaddr), 64'h500);
    chk("sim_ret_ack", 64'(ack), 64'h0);
    chk("sim_ret_depth", 64'(depth), 64'h0);
    step();
    chk("sim_tail_pc", 64'(irq_pc), 64'h1);
    chk("sim_tail_iaddr", 64'(iaddr), 64'h0);
    chk("sim_tail_ack", 64'(ack), 64'h01);
    irq = '0;
    step();
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("sim_final_iaddr", 64'(iaddr), 64'h600);
    chk("sim_final_depth", 64'(depth), 64'h0);
    step();

    // Underflow sets sticky error; reset clears everything.
    reti = 1'b1;
    step();
    reti = 1'b0;
    chk("uf_err", 64'(err), 64'h1);
    chk("uf_no_redirect", 64'(irq_pc), 64'h0);
    chk("uf_no_cc_ctrl", 64'(cc_ctrl), 64'h0);
    chk("uf_depth", 64'(depth), 64'h0);
    step();
    chk("uf_sticky", 64'(err), 64'h1);
    rst = 1'b1;
    step();
    chk_idle_outputs("rst2");

    // Reset mid-ISR discards context.
    rst = 1'b0; irq = 8'h08;
    step();
    chk("pre_rst_depth", 64'(depth), 64'h1);
    irq = '0; rst = 1'b1;
    step();
    chk_idle_outputs("rst3");
    rst = 1'b0; reti = 1'b1;
    step();
    reti = 1'b0;
    chk("post_rst_uf_err", 64'(err), 64'h1);
    chk("post_rst_no_redirect", 64'(irq_pc), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
